// File: rtl/jala_io_pkg.sv
// Shared register map for the JALA memory-mapped I/O responder: register offsets,
// STATUS/CTRL bit positions and the STATUS word packer.
package jala_io_pkg;

   localparam logic [2:0] IO_STATUS = 3'd0;
   localparam logic [2:0] IO_RXDATA = 3'd1;
   localparam logic [2:0] IO_TXDATA = 3'd2;
   localparam logic [2:0] IO_CTRL   = 3'd3;

   localparam int ST_RX_NEMPTY = 0;
   localparam int ST_TX_FULL   = 1;
   localparam int ST_TX_DROP   = 2;
   localparam int ST_RX_CNT    = 4;
   localparam int ST_TX_CNT    = 8;

   localparam int CTRL_CLR_DROP = 0;
   localparam int CTRL_FLUSH    = 1;

   function automatic logic [15:0] status_word(input logic       rx_nempty,
                                               input logic       tx_full,
                                               input logic       tx_drop,
                                               input logic [3:0] rx_cnt,
                                               input logic [3:0] tx_cnt);
      logic [15:0] w;
      w                    = '0;
      w[ST_RX_NEMPTY]      = rx_nempty;
      w[ST_TX_FULL]        = tx_full;
      w[ST_TX_DROP]        = tx_drop;
      w[ST_RX_CNT +: 4]    = rx_cnt;
      w[ST_TX_CNT +: 4]    = tx_cnt;
      return w;
   endfunction

endpackage

// File: rtl/jala_io_fifo.sv
// Small synchronous FIFO with flush; push is refused when full and pop when empty,
// both judged on the state before the clock edge.
module jala_io_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     CLK,
   input  logic                     IORst,
   input  logic                     Flush,
   input  logic                     Push,
   input  logic [WIDTH-1:0]         PushData,
   input  logic                     Pop,
   output logic [WIDTH-1:0]         Head,
   output logic                     Empty,
   output logic                     Full,
   output logic [$clog2(DEPTH):0]   Count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [AW-1:0] PTR_ONE = 1;
   localparam logic [CW-1:0] CNT_ONE = 1;

   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             do_push, do_pop;

   assign Empty   = (count_q == '0);
   assign Full    = (count_q == CW'(DEPTH));
   assign Count   = count_q;
   assign do_push = Push && !Full;
   assign do_pop  = Pop && !Empty;
   // An empty FIFO presents zero so stale storage never leaks onto the bus.
   assign Head    = Empty ? '0 : mem_q[rd_ptr_q];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (Flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
         if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
         case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (IORst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // NOTE: storage is deliberately not reset; the count alone decides what is valid.
   always_ff @(posedge CLK) begin
      if (do_push) mem_q[wr_ptr_q] <= PushData;
   end

endmodule

// File: rtl/jala_mmio_responder.sv
// MMIO responder for the CPU data port: decodes an 8-word window and serves
// STATUS/RXDATA/TXDATA/CTRL over two byte FIFOs (host RX, host TX).
module jala_mmio_responder
   import jala_io_pkg::*;
#(
   parameter logic [15:0] IO_BASE = 16'hFF00,
   parameter int          DEPTH   = 4
) (
   input  logic        CLK,
   input  logic        IORst,
   input  logic [15:0] MemAddr,
   input  logic        MemRead,
   input  logic        MemWrite,
   input  logic [15:0] MemWData,
   output logic [15:0] MemRData,
   output logic        Hit,
   input  logic [7:0]  HostRxData,
   input  logic        HostRxValid,
   output logic        HostRxReady,
   output logic [7:0]  HostTxData,
   output logic        HostTxValid,
   input  logic        HostTxReady
);

   localparam int CW = $clog2(DEPTH) + 1;

   logic          in_win, rd_hit, wr_hit;
   logic [2:0]    offset;
   logic          rx_pop, tx_push, flush, clr_drop;
   logic [7:0]    rx_head, tx_head;
   logic          rx_empty, rx_full, tx_empty, tx_full;
   logic [CW-1:0] rx_count, tx_count;
   logic [15:0]   rd_word;
   logic [15:0]   mem_rdata_q, mem_rdata_d;
   logic          hit_q, hit_d;
   logic          tx_drop_q, tx_drop_d;
   logic          unused_wdata;

   assign in_win   = (MemAddr[15:3] == IO_BASE[15:3]);
   assign offset   = MemAddr[2:0];
   assign rd_hit   = MemRead && in_win;
   assign wr_hit   = MemWrite && in_win;
   assign rx_pop   = rd_hit && (offset == IO_RXDATA);
   assign tx_push  = wr_hit && (offset == IO_TXDATA);
   assign flush    = wr_hit && (offset == IO_CTRL) && MemWData[CTRL_FLUSH];
   assign clr_drop = wr_hit && (offset == IO_CTRL) && MemWData[CTRL_CLR_DROP];
   assign unused_wdata = ^MemWData[15:8];

   jala_io_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_rx_fifo (
      .CLK      (CLK),
      .IORst    (IORst),
      .Flush    (flush),
      .Push     (HostRxValid),
      .PushData (HostRxData),
      .Pop      (rx_pop),
      .Head     (rx_head),
      .Empty    (rx_empty),
      .Full     (rx_full),
      .Count    (rx_count)
   );

   jala_io_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_tx_fifo (
      .CLK      (CLK),
      .IORst    (IORst),
      .Flush    (flush),
      .Push     (tx_push),
      .PushData (MemWData[7:0]),
      .Pop      (HostTxReady),
      .Head     (tx_head),
      .Empty    (tx_empty),
      .Full     (tx_full),
      .Count    (tx_count)
   );

   assign HostRxReady = !rx_full;
   assign HostTxValid = !tx_empty;
   assign HostTxData  = tx_head;
   assign MemRData    = mem_rdata_q;
   assign Hit         = hit_q;

   // NOTE: combinational blocks use blocking '=' with a default first so no latch is inferred.
   always_comb begin
      case (offset)
         IO_STATUS: rd_word = status_word(!rx_empty, tx_full, tx_drop_q,
                                          4'(rx_count), 4'(tx_count));
         IO_RXDATA: rd_word = {8'h00, rx_head};
         default:   rd_word = '0;
      endcase
      hit_d       = rd_hit;
      mem_rdata_d = rd_hit ? rd_word : mem_rdata_q;
      tx_drop_d   = tx_drop_q;
      if (tx_push && tx_full) tx_drop_d = 1'b1;
      if (clr_drop)           tx_drop_d = 1'b0;
   end

   always_ff @(posedge CLK) begin
      if (IORst) begin
         mem_rdata_q <= '0;
         hit_q       <= 1'b0;
         tx_drop_q   <= 1'b0;
      end else begin
         mem_rdata_q <= mem_rdata_d;
         hit_q       <= hit_d;
         tx_drop_q   <= tx_drop_d;
      end
   end

endmodule

// File: tb/tb_jala_mmio_responder.sv
// Self-checking bench for jala_mmio_responder: queue-based reference model checked
// every cycle, directed register-map scenarios, then randomized traffic.
module tb_jala_mmio_responder;

   localparam int DEPTH = 4;

   logic        CLK = 1'b0;
   logic        IORst = 1'b1;
   logic [15:0] MemAddr = '0;
   logic        MemRead = 1'b0;
   logic        MemWrite = 1'b0;
   logic [15:0] MemWData = '0;
   logic [15:0] MemRData;
   logic        Hit;
   logic [7:0]  HostRxData = '0;
   logic        HostRxValid = 1'b0;
   logic        HostRxReady;
   logic [7:0]  HostTxData;
   logic        HostTxValid;
   logic        HostTxReady = 1'b0;

   int n_checks = 0;
   int n_fail   = 0;
   bit chk_en   = 1'b0;

   // Reference model state
   byte unsigned rx_q[$];
   byte unsigned tx_q[$];
   bit           m_drop = 1'b0;
   bit           m_hit = 1'b0;
   logic [15:0]  m_rdata = '0;

   jala_mmio_responder #(.IO_BASE(16'hFF00), .DEPTH(DEPTH)) dut (
      .CLK         (CLK),
      .IORst       (IORst),
      .MemAddr     (MemAddr),
      .MemRead     (MemRead),
      .MemWrite    (MemWrite),
      .MemWData    (MemWData),
      .MemRData    (MemRData),
      .Hit         (Hit),
      .HostRxData  (HostRxData),
      .HostRxValid (HostRxValid),
      .HostRxReady (HostRxReady),
      .HostTxData  (HostTxData),
      .HostTxValid (HostTxValid),
      .HostTxReady (HostTxReady)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: full/empty judged on the queue sizes before the edge.
   always @(posedge CLK) begin : model
      int          rx_n, tx_n;
      bit          iw, rd, wr;
      int          off;
      logic [15:0] rv;
      if (IORst) begin
         rx_q.delete();
         tx_q.delete();
         m_drop  = 1'b0;
         m_hit   = 1'b0;
         m_rdata = '0;
      end else begin
         iw   = (MemAddr / 8) == (16'hFF00 / 8);
         off  = MemAddr % 8;
         rd   = MemRead && iw;
         wr   = MemWrite && iw;
         rx_n = rx_q.size();
         tx_n = tx_q.size();
         if (off == 0)
            rv = 16'(tx_n * 256 + rx_n * 16 + (m_drop ? 4 : 0)
                     + (tx_n == DEPTH ? 2 : 0) + (rx_n != 0 ? 1 : 0));
         else if (off == 1)
            rv = (rx_n != 0) ? 16'(rx_q[0]) : 16'h0000;
         else
            rv = 16'h0000;
         m_hit = rd;
         if (rd) m_rdata = rv;
         if (rd && off == 1 && rx_n > 0) void'(rx_q.pop_front());
         if (HostTxReady && tx_n > 0)   void'(tx_q.pop_front());
         if (HostRxValid && rx_n < DEPTH) rx_q.push_back(HostRxData);
         if (wr && off == 2) begin
            if (tx_n == DEPTH) m_drop = 1'b1;
            else               tx_q.push_back(MemWData[7:0]);
         end
         if (wr && off == 3) begin
            if (MemWData[0]) m_drop = 1'b0;
            if (MemWData[1]) begin
               rx_q.delete();
               tx_q.delete();
            end
         end
      end
   end

   // Every-cycle comparison against the model, on the falling edge.
   always @(negedge CLK) begin
      if (chk_en) begin
         check("cyc_rdata",    MemRData, m_rdata);
         check("cyc_hit",      16'(Hit), 16'(m_hit));
         check("cyc_rx_ready", 16'(HostRxReady), 16'(rx_q.size() < DEPTH));
         check("cyc_tx_valid", 16'(HostTxValid), 16'(tx_q.size() != 0));
         check("cyc_tx_data",  16'(HostTxData), (tx_q.size() != 0) ? 16'(tx_q[0]) : 16'h0000);
      end
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic cpu_read(input logic [15:0] addr);
      MemAddr = addr;
      MemRead = 1'b1;
      tick();
      MemRead = 1'b0;
   endtask

   task automatic cpu_write(input logic [15:0] addr, input logic [15:0] data);
      MemAddr  = addr;
      MemWData = data;
      MemWrite = 1'b1;
      tick();
      MemWrite = 1'b0;
   endtask

   task automatic host_push(input logic [7:0] b);
      HostRxData  = b;
      HostRxValid = 1'b1;
      tick();
      HostRxValid = 1'b0;
   endtask

   initial begin
      byte unsigned got[8];
      int           n;
      int           acc;

      // Reset
      IORst = 1'b1;
      tick();
      tick();
      IORst  = 1'b0;
      chk_en = 1'b1;
      check("rst_rx_ready", 16'(HostRxReady), 16'h1);
      check("rst_tx_valid", 16'(HostTxValid), 16'h0);
      check("rst_tx_data",  16'(HostTxData), 16'h0000);
      check("rst_hit",      16'(Hit), 16'h0);
      cpu_read(16'hFF00);
      check("rst_status",   MemRData, 16'h0000);
      check("rst_status_hit", 16'(Hit), 16'h1);
      check("model_rst_hit", 16'(m_hit), 16'h1);

      // RX path
      host_push(8'hA5);
      host_push(8'h3C);
      cpu_read(16'hFF00);
      check("rx_status_pre", MemRData, 16'h0021);
      cpu_read(16'hFF01);
      check("rx_rd0", MemRData, 16'h00A5);
      cpu_read(16'hFF01);
      check("rx_rd1", MemRData, 16'h003C);
      check("model_rx_rd1", m_rdata, 16'h003C);
      cpu_read(16'hFF01);
      check("rx_rd_empty", MemRData, 16'h0000);
      check("rx_rd_empty_hit", 16'(Hit), 16'h1);
      cpu_read(16'hFF00);
      check("rx_status_post", MemRData, 16'h0000);

      // RX full: valid held high across five bytes
      acc = 0;
      HostRxValid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         HostRxData = 8'(8'h11 * (i + 1));
         if (HostRxReady) acc++;
         tick();
      end
      check("rxf_accepted4", 16'(acc), 16'd4);
      check("rxf_ready_low", 16'(HostRxReady), 16'h0);
      HostRxData = 8'h55;
      tick();
      tick();
      check("rxf_still_full", 16'(HostRxReady), 16'h0);
      cpu_read(16'hFF01);
      check("rxf_pop_head", MemRData, 16'h0011);
      check("rxf_ready_after_pop", 16'(HostRxReady), 16'h1);
      tick();
      HostRxValid = 1'b0;
      cpu_read(16'hFF00);
      check("rxf_status", MemRData, 16'h0041);
      for (int i = 0; i < 4; i++) begin
         cpu_read(16'hFF01);
         check("rxf_order", MemRData, 16'(8'h22 + 8'h11 * i));
      end

      // TX overflow
      HostTxReady = 1'b0;
      for (int i = 1; i <= 5; i++) cpu_write(16'hFF02, 16'(i));
      cpu_read(16'hFF00);
      check("tx_status_drop", MemRData, 16'h0406);
      check("model_tx_status", m_rdata, 16'h0406);
      cpu_write(16'hFF03, 16'h0001);
      cpu_read(16'hFF00);
      check("tx_status_clr", MemRData, 16'h0402);
      n = 0;
      HostTxReady = 1'b1;
      for (int c = 0; c < 10; c++) begin
         if (HostTxValid && n < 8) begin
            got[n] = HostTxData;
            n++;
         end
         tick();
      end
      HostTxReady = 1'b0;
      check("tx_drained_n", 16'(n), 16'd4);
      for (int i = 0; i < 4; i++) check("tx_byte", 16'(got[i]), 16'(i + 1));
      check("tx_valid_after", 16'(HostTxValid), 16'h0);

      // Miss keeps MemRData, then flush
      host_push(8'h5A);
      cpu_read(16'hFF00);
      check("miss_pre_status", MemRData, 16'h0011);
      cpu_read(16'h1234);
      check("miss_hit", 16'(Hit), 16'h0);
      check("miss_rdata_held", MemRData, 16'h0011);
      cpu_write(16'hFF02, 16'h00C1);
      cpu_write(16'hFF02, 16'h00C2);
      cpu_read(16'hFF00);
      check("flush_pre_status", MemRData, 16'h0211);
      cpu_write(16'hFF03, 16'h0002);
      check("flush_tx_valid", 16'(HostTxValid), 16'h0);
      cpu_read(16'hFF00);
      check("flush_status", MemRData, 16'h0000);

      // Reset in the same cycle as an RXDATA read
      host_push(8'h5A);
      cpu_write(16'hFF02, 16'h0077);
      cpu_read(16'hFF00);
      check("mrst_pre_status", MemRData, 16'h0111);
      MemAddr = 16'hFF01;
      MemRead = 1'b1;
      IORst   = 1'b1;
      tick();
      MemRead = 1'b0;
      IORst   = 1'b0;
      check("mrst_hit", 16'(Hit), 16'h0);
      check("mrst_rdata", MemRData, 16'h0000);
      check("mrst_tx_valid", 16'(HostTxValid), 16'h0);
      check("mrst_rx_ready", 16'(HostRxReady), 16'h1);
      cpu_read(16'hFF00);
      check("mrst_status", MemRData, 16'h0000);

      // Randomized traffic against the model
      for (int c = 0; c < 3000; c++) begin
         MemAddr     = ($urandom_range(0, 7) == 0) ? 16'($urandom) : (16'hFF00 | 16'($urandom_range(0, 7)));
         MemRead     = ($urandom_range(0, 9) < 4);
         MemWrite    = ($urandom_range(0, 9) < 3);
         MemWData    = 16'($urandom);
         HostRxData  = 8'($urandom);
         HostRxValid = $urandom_range(0, 1);
         HostTxReady = ($urandom_range(0, 2) == 0);
         IORst       = ($urandom_range(0, 255) == 0);
         tick();
      end
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      HostRxValid = 1'b0;
      HostTxReady = 1'b0;
      IORst       = 1'b0;
      tick();
      tick();
      chk_en = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
